// File: rtl/calc_key_ctrl.sv
// calc_key_ctrl: keypad-entry sequencer for the 4-bit calculator datapath.
// Edge-detects the digit/function/equals/clear keys, assembles operand A,
// function code and operand B, strobes get_res for one cycle and latches
// the calculator result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// A_ENTRY | collecting operand A (last digit wins), waiting for func
// OP      | function latched, waiting for first digit of operand B
// B_ENTRY | collecting operand B, waiting for equals
// EXEC    | get_res high for one cycle, result captured at its end
// SHOW    | result displayed; a digit starts a fresh entry
module calc_key_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] key_digit,
   input  logic       key_func,
   input  logic [2:0] func_sel,
   input  logic       key_eq,
   input  logic       key_clr,
   input  logic [7:0] calc_res,
   output logic [3:0] input_a,
   output logic [3:0] input_b,
   output logic [2:0] func,
   output logic       get_res,
   output logic [7:0] result,
   output logic       result_valid,
   output logic       err
);

   typedef enum logic [2:0] {A_ENTRY, OP, B_ENTRY, EXEC, SHOW} state_t;

   state_t     state_q, state_d;
   logic       a_valid_q, a_valid_d;
   logic [3:0] input_a_q, input_a_d;
   logic [3:0] input_b_q, input_b_d;
   logic [2:0] func_q, func_d;
   logic       get_res_q, get_res_d;
   logic [7:0] result_q, result_d;
   logic       result_valid_q, result_valid_d;
   logic       err_q, err_d;

   logic [9:0] key_digit_q;
   logic       key_func_q, key_eq_q, key_clr_q;

   logic [9:0] dig_rise;
   logic       dig_one;
   logic [3:0] dig_val;
   logic       func_ev, eq_ev, clr_ev, func_legal;

   // Key edge detection: an event is a key sampled high that was low last edge.
   always_comb begin
      dig_rise   = key_digit & ~key_digit_q;
      dig_one    = (dig_rise != 10'd0) && ((dig_rise & (dig_rise - 10'd1)) == 10'd0);
      dig_val    = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (dig_rise[i]) dig_val = 4'(i);
      end
      func_ev    = key_func & ~key_func_q;
      eq_ev      = key_eq & ~key_eq_q;
      clr_ev     = key_clr & ~key_clr_q;
      func_legal = (func_sel <= 3'b101);
   end

   // Next-state and output-register logic; only the highest-priority event
   // present in a cycle is considered, even if the current state ignores it.
   always_comb begin
      state_d        = state_q;
      a_valid_d      = a_valid_q;
      input_a_d      = input_a_q;
      input_b_d      = input_b_q;
      func_d         = func_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      err_d          = err_q;

      if (clr_ev) begin
         state_d        = A_ENTRY;
         a_valid_d      = 1'b0;
         input_a_d      = 4'd0;
         input_b_d      = 4'd0;
         func_d         = 3'b000;
         result_d       = 8'd0;
         result_valid_d = 1'b0;
         err_d          = 1'b0;
      end else begin
         case (state_q)
            A_ENTRY: begin
               if (eq_ev) begin
               end else if (func_ev) begin
                  if (a_valid_q) begin
                     if (func_legal) begin
                        func_d  = func_sel;
                        state_d = OP;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end else if (dig_one) begin
                  input_a_d = dig_val;
                  a_valid_d = 1'b1;
               end
            end
            OP: begin
               if (eq_ev) begin
               end else if (func_ev) begin
                  if (func_legal) func_d = func_sel;
                  else            err_d  = 1'b1;
               end else if (dig_one) begin
                  input_b_d = dig_val;
                  state_d   = B_ENTRY;
               end
            end
            B_ENTRY: begin
               if (eq_ev) begin
                  if (func_q == 3'b011 && input_b_q == 4'd0) begin
                     err_d          = 1'b1;
                     result_d       = 8'd0;
                     result_valid_d = 1'b1;
                     state_d        = SHOW;
                  end else begin
                     state_d = EXEC;
                  end
               end else if (func_ev) begin
               end else if (dig_one) begin
                  input_b_d = dig_val;
               end
            end
            EXEC: begin
               result_d       = calc_res;
               result_valid_d = 1'b1;
               state_d        = SHOW;
            end
            SHOW: begin
               if (eq_ev || func_ev) begin
               end else if (dig_one) begin
                  input_a_d      = dig_val;
                  input_b_d      = 4'd0;
                  func_d         = 3'b000;
                  a_valid_d      = 1'b1;
                  result_valid_d = 1'b0;
                  err_d          = 1'b0;
                  state_d        = A_ENTRY;
               end
            end
            default: state_d = A_ENTRY;
         endcase
      end

      get_res_d = (state_d == EXEC);
   end

   // State, key history and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= A_ENTRY;
         a_valid_q      <= 1'b0;
         input_a_q      <= 4'd0;
         input_b_q      <= 4'd0;
         func_q         <= 3'b000;
         get_res_q      <= 1'b0;
         result_q       <= 8'd0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
         key_digit_q    <= 10'd0;
         key_func_q     <= 1'b0;
         key_eq_q       <= 1'b0;
         key_clr_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_valid_q      <= a_valid_d;
         input_a_q      <= input_a_d;
         input_b_q      <= input_b_d;
         func_q         <= func_d;
         get_res_q      <= get_res_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
         key_digit_q    <= key_digit;
         key_func_q     <= key_func;
         key_eq_q       <= key_eq;
         key_clr_q      <= key_clr;
      end
   end

   assign input_a      = input_a_q;
   assign input_b      = input_b_q;
   assign func         = func_q;
   assign get_res      = get_res_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign err          = err_q;

endmodule

// File: doc/calc_key_ctrl.md
# calc_key_ctrl

Keypad-entry sequencer for the 4-bit calculator datapath. Samples ten level-type decimal digit keys plus function, equals and clear keys, and assembles operand A, the function code and operand B. It then issues a single `get_res` strobe to the `calculator` instance and latches its 8-bit result. It sits between the keypad front end and `calculator`, and replaces free-running operand steering with a deterministic, clocked entry sequence.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `key_digit`  in  10  digit key levels; bit n = digit n (bit0 = zero … bit9 = nine). Synchronous to `clk`.
- `key_func`  in  1  function key level.
- `func_sel`  in  3  function code accompanying `key_func`: 000 +, 001 −, 010 ×, 011 /, 100 and, 101 or.
- `key_eq`  in  1  equals key level.
- `key_clr`  in  1  clear key level.
- `calc_res`  in  8  result from `calculator.res`.
- `input_a`  out  4  operand A to `calculator`.
- `input_b`  out  4  operand B to `calculator`.
- `func`  out  3  function code to `calculator`.
- `get_res`  out  1  one-cycle strobe to `calculator`.
- `result`  out  8  latched result.
- `result_valid`  out  1  `result` holds a completed computation.
- `err`  out  1  sticky error: illegal function code or divide by zero.

## Operation
- Reset values: `input_a`=0, `input_b`=0, `func`=000, `get_res`=0, `result`=0, `result_valid`=0, `err`=0. State is A_ENTRY and the internal `a_valid` flag is 0.
- Edge detection: each key is registered once, and an event is key & ~key_q. A held key produces exactly one event.
- Digit event: exactly one rising bit in `key_digit` in a cycle. Two or more rising bits in the same cycle are discarded without any state change.
- Event priority within one cycle: clr > eq > func > digit. Only the highest-priority event is acted on; the rest are dropped.
- Clear event in any state: the block returns to reset values, including `err`=0.
- States and transitions:
  - A_ENTRY
    - A digit sets `input_a`=d and `a_valid`=1. A later digit overwrites it (last digit wins).
    - A func event with `a_valid`=1 and `func_sel` ≤ 101 latches `func` and moves to OP.
    - A func event with `func_sel` > 101 sets `err`=1 and leaves state and `func` unchanged.
    - A func event with `a_valid`=0 is ignored.
    - An eq event is ignored.
  - OP
    - A digit sets `input_b`=d and moves to B_ENTRY.
    - A func event with a legal code overwrites `func`. An illegal code sets `err`.
    - An eq event is ignored.
  - B_ENTRY
    - A digit overwrites `input_b`.
    - A func event is ignored.
    - An eq event goes to EXEC. The exception is `func`=011 with `input_b`=0: this sets `err`=1, `result`=0 and `result_valid`=1, goes directly to SHOW, and issues no `get_res`.
  - EXEC (one cycle)
    - `get_res`=1 and all other events are ignored.
    - At the closing edge, `result` ← `calc_res`, `result_valid`=1, and the block moves to SHOW.
  - SHOW
    - A digit starts a new entry: `input_a`=d, `input_b`=0, `func`=000, `a_valid`=1, `result_valid`=0, `err`=0, and the block moves to A_ENTRY.
    - Func and eq events are ignored.
- `input_a`, `input_b` and `func` are stable from the cycle before EXEC through SHOW, so `calc_res` is valid during EXEC.
- `err` is sticky until a clear event or a new-entry digit.

## Timing
- All outputs are registered.
- A key event is acted on at the first rising edge where the key is sampled high with key_q=0, giving a one-edge reaction latency.
- Equals to result:
  - The eq event is sampled at edge k.
  - The block is in EXEC during cycle k..k+1, with `get_res` high for exactly that cycle.
  - `result` and `result_valid` update at edge k+1.
- Divide-by-zero path: `err`, `result_valid` and `result`=0 update at edge k, and `get_res` never rises.
- Reset asserted mid-operation, including during EXEC: all outputs go to reset values immediately (asynchronously) and `get_res` drops.
- After `rst` deasserts, key_q is 0, so a key held through reset produces an event on the first edge.

## Test plan
- Basic add:
  - Stimulus: reset, press 3, func 000, press 4, eq.
  - Required: `get_res` high for exactly one cycle, `result`=7 and `result_valid`=1 at edge k+1, `input_a`=3, `input_b`=4.
- Overwrite and held keys:
  - Stimulus: press 2, then press 5; hold 9 for 10 cycles in OP; func 010; eq.
  - Required: `input_a`=5, `input_b`=9 (a single event from the held key), `result`=45.
- Divide by zero:
  - Stimulus: press 6, func 011, press 0, eq.
  - Required: `err`=1, `result`=0, `result_valid`=1, `get_res` never asserted.
- Illegal and simultaneous inputs:
  - Stimulus: func with `func_sel`=111 in A_ENTRY; digits 1 and 2 rising in the same cycle; eq and digit 7 in the same cycle in B_ENTRY.
  - Required: `err`=1 with the state unchanged; no operand change from the double digit; EXEC entered and `input_b` unchanged.
- Clear and restart:
  - Stimulus: in SHOW press 8, check the state; then clr mid-entry.
  - Required: after pressing 8, `result_valid`=0, `input_a`=8, `input_b`=0. After clr, all outputs are at reset values.
- Asynchronous reset:
  - Stimulus: assert `rst` during EXEC, between clock edges.
  - Required: `get_res`, `result_valid` and `err` go to 0 immediately, and the block is in A_ENTRY after release.
